// File: rtl/bitserial_collect_pkg.sv
// Shared definitions for the bit-serial adder slice: default operand width and
// collector state encodings, also used by the adder bench and upstream serializer.
package bitserial_collect_pkg;

  localparam int BS_WIDTH_DEFAULT = 4;

  typedef enum logic {
    BS_IDLE  = 1'b0,
    BS_SHIFT = 1'b1
  } bs_state_e;

endpackage

// File: rtl/bitserial_collect_if.sv
// Serial input stream plus valid/ready parallel output of the sum collector.
interface bitserial_collect_if #(
  parameter int WIDTH = bitserial_collect_pkg::BS_WIDTH_DEFAULT
);
  logic             sin;
  logic             sin_valid;
  logic             sin_first;
  logic [WIDTH:0]   sum;
  logic             sum_valid;
  logic             sum_ready;
  logic             busy;
  logic             overrun;
  logic             frame_err;

  modport master (
    output sin, sin_valid, sin_first, sum_ready,
    input  sum, sum_valid, busy, overrun, frame_err
  );

  modport slave (
    input  sin, sin_valid, sin_first, sum_ready,
    output sum, sum_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/bitserial_collect_outbuf.sv
// One-entry valid/ready holding register; load may coincide with an accept of the
// previous entry, in which case the entry stays full with the new data.
module bitserial_outbuf #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         full
);
  logic [W-1:0] data_r;
  logic         full_r;

  // holding register and its occupancy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r <= '0;
      full_r <= 1'b0;
    end else if (load) begin
      data_r <= din;
      full_r <= 1'b1;
    end else if (full_r && ready) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign dout = data_r;
  assign full = full_r;
endmodule

// File: rtl/bitserial_collect.sv
// Collects an LSB-first serial sum frame of WIDTH+1 bits into a parallel word and
// hands it to a one-entry output buffer, flagging dropped frames and restarts.
module bitserial_collect
  import bitserial_collect_pkg::*;
#(
  parameter int WIDTH = BS_WIDTH_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  bitserial_collect_if.slave bus
);
  localparam int FRAME = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 2);

  bs_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH:0]   shreg_r, shreg_s;
  logic             complete_s;
  logic             frame_err_s;
  logic             load_s;
  logic             overrun_s;
  logic             full_s;
  logic             busy_r;
  logic             overrun_r;
  logic             frame_err_r;

  // next-state, bit placement and completion detection
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    shreg_s     = shreg_r;
    complete_s  = 1'b0;
    frame_err_s = 1'b0;
    case (state_r)
      BS_IDLE: begin
        if (bus.sin_valid && bus.sin_first) begin
          shreg_s = {{WIDTH{1'b0}}, bus.sin};
          cnt_s   = CNT_W'(1);
          state_s = BS_SHIFT;
        end else begin
          state_s = BS_IDLE;
        end
      end
      BS_SHIFT: begin
        if (bus.sin_valid && bus.sin_first) begin
          frame_err_s = 1'b1;
          shreg_s     = {{WIDTH{1'b0}}, bus.sin};
          cnt_s       = CNT_W'(1);
        end else if (bus.sin_valid) begin
          shreg_s[cnt_r] = bus.sin;
          if (cnt_r == CNT_W'(FRAME - 1)) begin
            complete_s = 1'b1;
            cnt_s      = '0;
            state_s    = BS_IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = BS_SHIFT;
        end
      end
      default: begin
        state_s = BS_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // a finished word lands only if the buffer is empty or being drained this cycle
  assign load_s    = complete_s && (!full_s || bus.sum_ready);
  assign overrun_s = complete_s && full_s && !bus.sum_ready;

  // FSM, counter, shift register and registered status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= BS_IDLE;
      cnt_r       <= '0;
      shreg_r     <= '0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      shreg_r     <= shreg_s;
      busy_r      <= (state_s == BS_SHIFT);
      overrun_r   <= overrun_s;
      frame_err_r <= frame_err_s;
    end
  end

  bitserial_outbuf #(.W(WIDTH + 1)) u_outbuf (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .din   (shreg_s),
    .ready (bus.sum_ready),
    .dout  (bus.sum),
    .full  (full_s)
  );

  assign bus.sum_valid = full_s;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;
endmodule

// File: tb/tb_bitserial_collect.sv
// Directed bench for bitserial_collect (WIDTH=4): inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that updates them.
`timescale 1ns/1ps
module tb_bitserial_collect;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  bitserial_collect_if #(.WIDTH(WIDTH)) bus ();

  bitserial_collect #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #50 clk = ~clk;

  task automatic step(input logic v, input logic f, input logic b);
    @(negedge clk);
    bus.sin_valid = v;
    bus.sin_first = f;
    bus.sin       = b;
  endtask

  task automatic send_frame(input logic [4:0] w);
    step(1'b1, 1'b1, w[0]);
    for (int i = 1; i < 5; i++) step(1'b1, 1'b0, w[i]);
  endtask

  task automatic test_reset;
    bus.sin = 1'b0; bus.sin_valid = 1'b0; bus.sin_first = 1'b0; bus.sum_ready = 1'b1;
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if ({bus.sum, bus.sum_valid, bus.busy, bus.overrun, bus.frame_err} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got sum=%0d v=%b busy=%b ovr=%b ferr=%b, expected all 0",
               bus.sum, bus.sum_valid, bus.busy, bus.overrun, bus.frame_err);
    end
    reset = 1'b0;
    // bits without a frame start must be ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.busy !== 1'b0 || bus.sum_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_ignore: got busy=%b valid=%b, expected 0 0", bus.busy, bus.sum_valid);
    end
  endtask

  task automatic test_basic;
    bus.sum_ready = 1'b1;
    send_frame(5'b10100);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum !== 5'd20 || bus.sum_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL basic_sum: got sum=%0d v=%b ovr=%b, expected 20 1 0",
               bus.sum, bus.sum_valid, bus.overrun);
    end
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_one_cycle: got valid=%b, expected 0", bus.sum_valid);
    end
  endtask

  task automatic test_gaps;
    bus.sum_ready = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.busy !== 1'b1) begin
      fails++; $display("FAIL gaps_busy0: got %b, expected 1", bus.busy);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.busy !== 1'b1 || bus.sum_valid !== 1'b0) begin
      fails++; $display("FAIL gaps_busy3: got busy=%b v=%b, expected 1 0", bus.busy, bus.sum_valid);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum !== 5'd20 || bus.sum_valid !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL gaps_sum: got sum=%0d v=%b busy=%b, expected 20 1 0",
               bus.sum, bus.sum_valid, bus.busy);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    bus.sum_ready = 1'b0;
    send_frame(5'b10100);
    step(1'b0, 1'b0, 1'b0);
    send_frame(5'b01000);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.overrun !== 1'b1 || bus.sum !== 5'd20 || bus.sum_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_overrun: got ovr=%b sum=%0d v=%b, expected 1 20 1",
               bus.overrun, bus.sum, bus.sum_valid);
    end
    step(1'b0, 1'b0, 1'b0);
    bus.sum_ready = 1'b1;
    tests++;
    if (bus.overrun !== 1'b0 || bus.sum !== 5'd20) begin
      fails++;
      $display("FAIL bp_pulse_hold: got ovr=%b sum=%0d, expected 0 20", bus.overrun, bus.sum);
    end
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum_valid !== 1'b0) begin
      fails++; $display("FAIL bp_accept: got valid=%b, expected 0", bus.sum_valid);
    end
  endtask

  task automatic test_full_accept;
    bus.sum_ready = 1'b0;
    send_frame(5'b10100);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    bus.sum_ready = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum !== 5'd8 || bus.sum_valid !== 1'b1 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL full_accept: got sum=%0d v=%b ovr=%b, expected 8 1 0",
               bus.sum, bus.sum_valid, bus.overrun);
    end
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum_valid !== 1'b0) begin
      fails++; $display("FAIL full_drain: got valid=%b, expected 0", bus.sum_valid);
    end
  endtask

  task automatic test_restart;
    bus.sum_ready = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    tests++;
    if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_err: got ferr=%b busy=%b, expected 1 1", bus.frame_err, bus.busy);
    end
    step(1'b1, 1'b0, 1'b1);
    tests++;
    if (bus.frame_err !== 1'b0) begin
      fails++; $display("FAIL restart_pulse: got ferr=%b, expected 0", bus.frame_err);
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum !== 5'd30 || bus.sum_valid !== 1'b1) begin
      fails++;
      $display("FAIL restart_sum: got sum=%0d v=%b, expected 30 1", bus.sum, bus.sum_valid);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_midframe_reset;
    bus.sum_ready = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tests++;
    if ({bus.sum, bus.sum_valid, bus.busy, bus.overrun, bus.frame_err} !== 9'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got sum=%0d v=%b busy=%b ovr=%b ferr=%b, expected all 0",
               bus.sum, bus.sum_valid, bus.busy, bus.overrun, bus.frame_err);
    end
    send_frame(5'b10100);
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (bus.sum !== 5'd20 || bus.sum_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL midreset_sum: got sum=%0d v=%b ferr=%b, expected 20 1 0",
               bus.sum, bus.sum_valid, bus.frame_err);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_full_accept();
    test_restart();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
